serial_adder_unit: RTL

Bit-serial adder/subtractor that consumes the serial streams of two upstream operand shift registers, addend and augend. Each operand is 8 bits and streams LSB first, one bit per CLK.
- A carry flip-flop produces one sum bit per cycle.
- Sum bits shift into an internal result register.
- A small FSM sequences WIDTH bits and flags completion with a one-cycle pulse.
The unit sits directly downstream of the operand shift registers and presents a parallel result to the rest of the datapath.

---
 rtl/serial_adder_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_adder_unit.sv
// Bit-serial adder/subtractor: consumes two LSB-first operand streams and
// presents a parallel WIDTH-bit result with carry-out and overflow.
module serial_adder_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             Start,
    input  logic             Sub,
    input  logic             A_in,
    input  logic             B_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             sub_q;
    logic [WIDTH-1:0] shreg_q;

    logic             load;
    logic             last;
    logic             b_eff;
    logic             s_bit;
    logic             carry_d;
    logic [WIDTH-1:0] shreg_d;

    // State register
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and one-bit full adder
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        b_eff   = B_in ^ sub_q;
        s_bit   = A_in ^ b_eff ^ carry_q;
        carry_d = (A_in & b_eff) | (A_in & carry_q) | (b_eff & carry_q);
        shreg_d = {s_bit, shreg_q[WIDTH-1:1]};
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    last    = 1'b1;
                end
            end
            DONE: begin
                if (Start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial datapath and registered outputs; carry_q is the carry into the
    // MSB on the final bit, so overflow needs no separate capture register.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            shreg_q <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            Busy <= (state_d == RUN);
            Done <= (state_d == DONE);
            if (load) begin
                cnt_q   <= '0;
                sub_q   <= Sub;
                carry_q <= Sub;
                shreg_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q   <= cnt_q + CW'(1);
                carry_q <= carry_d;
                shreg_q <= shreg_d;
                if (last) begin
                    Sum  <= shreg_d;
                    Cout <= carry_d;
                    Ovf  <= carry_q ^ carry_d;
                end
            end
        end
    end

endmodule
